// File: rtl/clock_display_scan.sv
// HH:MM:SS real-time clock with set mode, field blink and an 8-digit multiplexed 7-segment scanner.
// Everything runs on clk; second/minute carries are single-cycle pulses.
module clock_display_scan #(
    parameter int unsigned CLK_HZ     = 1000,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned HOUR_24    = 1,
    parameter int unsigned SCAN_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [7:0] seg_com,
    output logic [7:0] seg_data,
    output logic       sec_tick,
    output logic       min_tick
);

    localparam int unsigned PW       = $clog2(CLK_HZ);
    localparam int unsigned HALF     = CLK_HZ / 2;
    localparam int unsigned BW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [4:0]  HOUR_RST = (HOUR_24 != 0) ? 5'd0 : 5'd12;

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          pm_q, pm_d;
    logic          sec_tick_q, sec_tick_d;
    logic          min_tick_q, min_tick_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seg_com_q, seg_com_d;
    logic [7:0]    seg_data_q, seg_data_d;

    logic [4:0] hour_nx;
    logic       pm_nx;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic       blank_c;

    function automatic logic [7:0] font(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    // Hour successor, shared by the running carry and the set-mode increment.
    always_comb begin
        hour_nx = hour_q;
        pm_nx   = pm_q;
        if (HOUR_24 != 0) begin
            hour_nx = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
            hour_nx = (hour_q == 5'd12) ? 5'd1 : hour_q + 5'd1;
            if (hour_q == 5'd11) begin
                pm_nx = ~pm_q;
            end
        end
    end

    // Prescaler and timekeeping; set mode freezes the prescaler and edits one field without carry.
    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        pm_d       = pm_q;
        sec_tick_d = 1'b0;
        min_tick_d = 1'b0;
        if (set_en) begin
            presc_d = '0;
            if (inc) begin
                case (set_sel)
                    2'd0: sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    2'd1: min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    2'd2: begin
                        hour_d = hour_nx;
                        pm_d   = pm_nx;
                    end
                    default: ;
                endcase
            end
        end else if (presc_q == PW'(CLK_HZ - 1)) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d      = 6'd0;
                min_tick_d = 1'b1;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = hour_nx;
                    pm_d   = pm_nx;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Free-running blink phase and digit scan index.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BW'(HALF - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Digit decode: select and data are registered together from the same idx.
    always_comb begin
        sec_ones  = 4'(sec_q % 6'd10);
        sec_tens  = 4'(sec_q / 6'd10);
        min_ones  = 4'(min_q % 6'd10);
        min_tens  = 4'(min_q / 6'd10);
        hour_ones = 4'(hour_q % 5'd10);
        hour_tens = 4'(hour_q / 5'd10);
        seg_com_d = ~(8'h80 >> idx_q);
        case (idx_q)
            3'd0: seg_data_d = font(sec_ones);
            3'd1: seg_data_d = font(sec_tens);
            3'd2: seg_data_d = font(min_ones) | 8'h01;
            3'd3: seg_data_d = font(min_tens);
            3'd4: seg_data_d = font(hour_ones) | 8'h01;
            3'd5: seg_data_d = ((HOUR_24 == 0) && (hour_tens == 4'd0)) ? 8'h00 : font(hour_tens);
            3'd6: seg_data_d = (HOUR_24 != 0) ? 8'h00 : (pm_q ? 8'hCE : 8'hEE);
            default: seg_data_d = 8'h00;
        endcase
        // idx[2:1] is the field number of a time digit; digits 6/7 map to 3 and never blink.
        blank_c = set_en && blink_q && (set_sel != 2'd3) && (idx_q[2:1] == set_sel);
        if (blank_c) begin
            seg_data_d = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= HOUR_RST;
            pm_q        <= 1'b0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            seg_com_q   <= 8'hFF;
            seg_data_q  <= 8'h00;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            pm_q        <= pm_d;
            sec_tick_q  <= sec_tick_d;
            min_tick_q  <= min_tick_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            seg_com_q   <= seg_com_d;
            seg_data_q  <= seg_data_d;
        end
    end

    assign seg_com  = seg_com_q;
    assign seg_data = seg_data_q;
    assign sec_tick = sec_tick_q;
    assign min_tick = min_tick_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: three instances (24h/8 digits, 12h/8 digits, 24h/6 digits with slow scan)
// checked cycle by cycle against a queue of expected display and tick values.
module tb_clock_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_a, inc_a, set_b, inc_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] com24, dat24, com12, dat12, com6, dat6;
    logic       st24, mt24, st12, mt12, st6, mt6;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    logic [15:0] q24[$];
    logic [15:0] q12[$];
    logic [15:0] q6[$];
    logic [1:0]  qta[$];
    logic [1:0]  qtb[$];

    logic [7:0] font_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    clock_display_scan #(.CLK_HZ(4), .NUM_DIGITS(8), .HOUR_24(1), .SCAN_DIV(1)) u24 (
        .clk(clk), .rst(rst), .set_en(set_a), .set_sel(sel_a), .inc(inc_a),
        .seg_com(com24), .seg_data(dat24), .sec_tick(st24), .min_tick(mt24));

    clock_display_scan #(.CLK_HZ(4), .NUM_DIGITS(6), .HOUR_24(1), .SCAN_DIV(3)) u6 (
        .clk(clk), .rst(rst), .set_en(set_a), .set_sel(sel_a), .inc(inc_a),
        .seg_com(com6), .seg_data(dat6), .sec_tick(st6), .min_tick(mt6));

    clock_display_scan #(.CLK_HZ(4), .NUM_DIGITS(8), .HOUR_24(0), .SCAN_DIV(1)) u12 (
        .clk(clk), .rst(rst), .set_en(set_b), .set_sel(sel_b), .inc(inc_b),
        .seg_com(com12), .seg_data(dat12), .sec_tick(st12), .min_tick(mt12));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Expected {seg_com, seg_data} for scan slot u (u = edges since reset release minus one).
    function automatic logic [15:0] model(input int u, input int ndig, input int div, input bit h24,
                                          input int hh, input int mm, input int ss, input bit pm,
                                          input bit sen, input int sel);
        int d;
        bit ph;
        logic [7:0] one, dat;
        d   = (u / div) % ndig;
        ph  = ((u / 2) % 2) == 1;
        one = 8'h80 >> d;
        case (d)
            0: dat = font_tab[ss % 10];
            1: dat = font_tab[ss / 10];
            2: dat = font_tab[mm % 10] | 8'h01;
            3: dat = font_tab[mm / 10];
            4: dat = font_tab[hh % 10] | 8'h01;
            5: dat = (!h24 && hh < 10) ? 8'h00 : font_tab[hh / 10];
            6: dat = h24 ? 8'h00 : (pm ? 8'hCE : 8'hEE);
            default: dat = 8'h00;
        endcase
        if (sen && ph && ((sel == 0 && d <= 1) || (sel == 1 && (d == 2 || d == 3)) ||
                          (sel == 2 && (d == 4 || d == 5))))
            dat = 8'h00;
        return {~one, dat};
    endfunction

    task automatic push_a(input int n, input int hh, input int mm, input int ss, input bit sen, input int sel);
        for (int k = 0; k < n; k++) begin
            q24.push_back(model(t + k, 8, 1, 1'b1, hh, mm, ss, 1'b0, sen, sel));
            q6.push_back(model(t + k, 6, 3, 1'b1, hh, mm, ss, 1'b0, sen, sel));
        end
    endtask

    task automatic push_b(input int n, input int hh, input int mm, input int ss, input bit pm);
        for (int k = 0; k < n; k++)
            q12.push_back(model(t + k, 8, 1, 1'b0, hh, mm, ss, pm, 1'b1, 3));
    endtask

    // Advance n cycles; compare every pending expectation, ticks default to zero.
    task automatic run(input int n);
        logic [1:0] tk;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            t++;
            if (q24.size() > 0) chk("seg24", {com24, dat24}, q24.pop_front());
            if (q6.size() > 0)  chk("seg6", {com6, dat6}, q6.pop_front());
            if (q12.size() > 0) chk("seg12", {com12, dat12}, q12.pop_front());
            tk = (qta.size() > 0) ? qta.pop_front() : 2'b00;
            chk("tick24", {14'd0, st24, mt24}, {14'd0, tk});
            chk("tick6", {14'd0, st6, mt6}, {14'd0, tk});
            tk = (qtb.size() > 0) ? qtb.pop_front() : 2'b00;
            chk("tick12", {14'd0, st12, mt12}, {14'd0, tk});
        end
    endtask

    task automatic pulse_a(input int n);
        for (int i = 0; i < n; i++) begin
            inc_a = 1'b1; run(1);
            inc_a = 1'b0; run(1);
        end
    endtask

    task automatic pulse_b(input int n);
        for (int i = 0; i < n; i++) begin
            inc_b = 1'b1; run(1);
            inc_b = 1'b0; run(1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_com24"}, {8'h00, com24}, 16'h00FF);
        chk({tag, "_dat24"}, {8'h00, dat24}, 16'h0000);
        chk({tag, "_com6"}, {8'h00, com6}, 16'h00FF);
        chk({tag, "_dat6"}, {8'h00, dat6}, 16'h0000);
        chk({tag, "_com12"}, {8'h00, com12}, 16'h00FF);
        chk({tag, "_dat12"}, {8'h00, dat12}, 16'h0000);
        chk({tag, "_ticks"}, {10'd0, st24, mt24, st6, mt6, st12, mt12}, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        set_a = 1'b1; sel_a = 2'd3; inc_a = 1'b0;
        set_b = 1'b1; sel_b = 2'd3; inc_b = 1'b0;
        run(2);
        chk_reset_outputs("reset");
        rst = 1'b0;
        t = 0;

        // Power-on scan order and contents.
        push_a(24, 0, 0, 0, 1'b1, 3);
        push_b(24, 12, 0, 0, 1'b0);
        run(24);

        // 61 minute increments wrap to 01 without touching the hour.
        sel_a = 2'd1; pulse_a(61); sel_a = 2'd3; run(1);
        push_a(24, 0, 1, 0, 1'b1, 3); run(24);

        // Set 23:59:58, then watch each field blink.
        sel_a = 2'd2; pulse_a(23);
        sel_a = 2'd1; pulse_a(58);
        sel_a = 2'd0; pulse_a(58);
        sel_a = 2'd3; run(1);
        push_a(24, 23, 59, 58, 1'b1, 3); run(24);
        sel_a = 2'd0; push_a(24, 23, 59, 58, 1'b1, 0); run(24);
        sel_a = 2'd1; push_a(24, 23, 59, 58, 1'b1, 1); run(24);

        // Run: tick 4 clocks after release, full wrap on the second; inc ignored while running.
        set_a = 1'b0; sel_a = 2'd0;
        qta.push_back(2'b00); qta.push_back(2'b00); qta.push_back(2'b00); qta.push_back(2'b10);
        qta.push_back(2'b00); qta.push_back(2'b00); qta.push_back(2'b00); qta.push_back(2'b11);
        run(1); inc_a = 1'b1; run(1); inc_a = 1'b0; run(6);
        set_a = 1'b1; sel_a = 2'd3;
        push_a(24, 0, 0, 0, 1'b1, 3); run(24);

        // set_en reasserted on the terminal prescaler edge suppresses the tick.
        set_a = 1'b0; run(3); set_a = 1'b1; run(3);
        push_a(24, 0, 0, 0, 1'b1, 3); run(24);

        // inc with set_sel=3 changes nothing.
        pulse_a(3);
        push_a(24, 0, 0, 0, 1'b1, 3); run(24);

        // 12h: set 11:59:59 AM, roll to 12:00:00 PM.
        sel_b = 2'd2; pulse_b(11);
        sel_b = 2'd1; pulse_b(59);
        sel_b = 2'd0; pulse_b(59);
        sel_b = 2'd3; run(1);
        push_b(24, 11, 59, 59, 1'b0); run(24);
        set_b = 1'b0;
        qtb.push_back(2'b00); qtb.push_back(2'b00); qtb.push_back(2'b00); qtb.push_back(2'b11);
        run(4);
        set_b = 1'b1;
        push_b(24, 12, 0, 0, 1'b1); run(24);

        // 12->1..9 keeps PM with blank hour tens; 11->12 in set mode flips to AM.
        sel_b = 2'd2; pulse_b(9); sel_b = 2'd3; run(1);
        push_b(24, 9, 0, 0, 1'b1); run(24);
        sel_b = 2'd2; pulse_b(3); sel_b = 2'd3; run(1);
        push_b(24, 12, 0, 0, 1'b0); run(24);

        // Reset in the middle of a scan at 12:34:56.
        sel_a = 2'd2; pulse_a(12);
        sel_a = 2'd1; pulse_a(34);
        sel_a = 2'd0; pulse_a(56);
        sel_a = 2'd3; run(1);
        push_a(10, 12, 34, 56, 1'b1, 3); run(10);
        rst = 1'b1;
        #2;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        push_a(24, 0, 0, 0, 1'b1, 3);
        push_b(24, 12, 0, 0, 1'b0);
        run(24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
